regbank_sb: RTL and testbench

//  Parametrised register bank: NREG x WIDTH registers, one write port, two combinational read ports.
//  Top register is the program counter, with auto-increment.

---
 rtl/regbank_pkg.sv | 14 +
 rtl/regbank_sb_scoreboard.sv | 38 +++
 rtl/regbank_sb.sv | 114 +++++++++++
 tb/tb_regbank_sb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank: opcodes that never write back,
// and the helper that recognises them.
package regbank_pkg;

  localparam logic [3:0] OP_NOP = 4'hF;
  localparam logic [3:0] OP_STR = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hB;

  // True when the instruction carries no register writeback.
  function automatic logic no_wb(input logic [3:0] opcode);
    return (opcode == OP_NOP) || (opcode == OP_STR) || (opcode == OP_CMP);
  endfunction

endpackage

// File: rtl/regbank_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a multi-cycle
// op and cleared by its writeback; stall flags reads of still-pending registers.
module regbank_sb_scoreboard
  import regbank_pkg::*;
#(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [NREG-1:0] pending,
  output logic            stall
);

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  assign set_mask = set_en ? (NREG'(1) << set_idx) : '0;
  assign clr_mask = clr_en ? (NREG'(1) << clr_idx) : '0;

  // Set is applied after clear so a back-to-back load keeps its bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign stall = pending[rd_addr1] | pending[rd_addr2];

endmodule

// File: rtl/regbank_sb.sv
// Register bank with program-counter top register, write forwarding and a
// pending-write scoreboard that stalls reads of registers awaiting a load.
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREG    = 16,
  parameter int PC_W    = 16,
  parameter int PC_RST  = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               opcode,
  input  logic                     wr_en,
  input  logic [$clog2(NREG)-1:0]  wr_dest,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     issue_en,
  input  logic [$clog2(NREG)-1:0]  issue_dest,
  input  logic                     pc_inc,
  input  logic [$clog2(NREG)-1:0]  rd_addr1,
  input  logic [$clog2(NREG)-1:0]  rd_addr2,
  output logic [WIDTH-1:0]         rd_data1,
  output logic [WIDTH-1:0]         rd_data2,
  output logic [PC_W-1:0]          pc,
  output logic                     stall,
  output logic [NREG-1:0]          pending
);

  localparam int AW     = $clog2(NREG);
  localparam int PC_IDX = NREG - 1;
  localparam logic [AW-1:0] PC_ADDR = AW'(NREG - 1);
  localparam logic [WIDTH-1:0] PC_MASK =
    (PC_W >= WIDTH) ? {WIDTH{1'b1}} : ((WIDTH'(1) << PC_W) - WIDTH'(1));
  localparam logic [WIDTH-1:0] PC_RST_VAL = WIDTH'(PC_RST) & PC_MASK;

  logic [WIDTH-1:0] regs [NREG];
  logic             we;
  logic             issue_ok;
  logic [WIDTH-1:0] wr_fwd;
  logic [WIDTH-1:0] pc_next;

  assign we       = wr_en && !no_wb(opcode) && !((ZERO_R0 != 0) && (wr_dest == '0));
  assign issue_ok = issue_en && !((ZERO_R0 != 0) && (issue_dest == '0));

  // Forwarded data matches what the register will hold, so PC writes are masked.
  assign wr_fwd = (wr_dest == PC_ADDR) ? (wr_data & PC_MASK) : wr_data;

  always_comb begin
    pc_next = regs[PC_IDX];
    if (we && (wr_dest == PC_ADDR)) begin
      pc_next = wr_data & PC_MASK;
    end else if (pc_inc) begin
      pc_next = (regs[PC_IDX] + WIDTH'(1)) & PC_MASK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG - 1; i++) begin
        regs[i] <= '0;
      end
      regs[PC_IDX] <= PC_RST_VAL;
    end else begin
      for (int i = 0; i < NREG - 1; i++) begin
        if (we && (wr_dest == AW'(i))) begin
          regs[i] <= wr_data;
        end
      end
      regs[PC_IDX] <= pc_next;
    end
  end

  // The PC increment is never forwarded; only a real writeback is.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if ((BYPASS != 0) && we && (wr_dest == rd_addr1)) begin
      rd_data1 = wr_fwd;
    end
    if ((ZERO_R0 != 0) && (rd_addr1 == '0)) begin
      rd_data1 = '0;
    end
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if ((BYPASS != 0) && we && (wr_dest == rd_addr2)) begin
      rd_data2 = wr_fwd;
    end
    if ((ZERO_R0 != 0) && (rd_addr2 == '0)) begin
      rd_data2 = '0;
    end
  end

  assign pc = regs[PC_IDX][PC_W-1:0];

  regbank_sb_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (issue_ok),
    .set_idx  (issue_dest),
    .clr_en   (we),
    .clr_idx  (wr_dest),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .pending  (pending),
    .stall    (stall)
  );

endmodule

// File: tb/tb_regbank_sb.sv
// Directed bench for regbank_sb: expectations are queued as stimulus is applied
// and popped against DUT outputs once they have settled.
module tb_regbank_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        wr_en;
  logic [3:0]  wr_dest;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic        pc_inc;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic [15:0] pc;
  logic        stall;
  logic [15:0] pending;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  regbank_sb dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .wr_en      (wr_en),
    .wr_dest    (wr_dest),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .pc_inc     (pc_inc),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .pc         (pc),
    .stall      (stall),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $error("[TB] FAIL no_expectation observed=%h required=<queued value>", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === e.value) passed++;
      else $error("[TB] FAIL %s observed=%h required=%h", e.tag, observed, e.value);
    end
  endtask

  task automatic apply_stimulus(input logic we_i, input logic [3:0] op_i,
                                input logic [3:0] dest_i, input logic [31:0] data_i,
                                input logic iss_i, input logic [3:0] iss_dest_i,
                                input logic inc_i);
    wr_en      = we_i;
    opcode     = op_i;
    wr_dest    = dest_i;
    wr_data    = data_i;
    issue_en   = iss_i;
    issue_dest = iss_dest_i;
    pc_inc     = inc_i;
  endtask

  initial begin
    reset    = 1'b0;
    rd_addr1 = 4'd0;
    rd_addr2 = 4'd0;
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);

    // Reset state
    #12;
    expect_val("reset_pending", 32'h0); check_output({16'h0, pending});
    expect_val("reset_stall", 32'h0);   check_output({31'h0, stall});
    expect_val("reset_pc", 32'h1);      check_output({16'h0, pc});
    @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd_addr1 = 4'(a);
      rd_addr2 = 4'(15 - a);
      #1;
      expect_val($sformatf("reset_rd1_r%0d", a), (a == 15) ? 32'h1 : 32'h0);
      check_output(rd_data1);
      expect_val($sformatf("reset_rd2_r%0d", 15 - a), (a == 0) ? 32'h1 : 32'h0);
      check_output(rd_data2);
    end

    // Bypass of a qualified write, then a gated STR write
    @(negedge clk);
    rd_addr1 = 4'd3;
    rd_addr2 = 4'd0;
    apply_stimulus(1'b1, 4'h0, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b0);
    expect_val("bypass_r3", 32'hDEAD_BEEF);
    #1 check_output(rd_data1);
    @(negedge clk);
    apply_stimulus(1'b1, 4'hE, 4'd3, 32'h1234_5678, 1'b0, 4'd0, 1'b0);
    expect_val("str_no_bypass_r3", 32'hDEAD_BEEF);
    #1 check_output(rd_data1);
    @(negedge clk);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    expect_val("str_no_write_r3", 32'hDEAD_BEEF);
    #1 check_output(rd_data1);

    // PC increment, write-wins, wrap
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1);
      expect_val($sformatf("pc_inc_%0d", k), 32'(k + 1));
      #1 check_output({16'h0, pc});
      @(negedge clk);
    end
    expect_val("pc_after_inc", 32'h4);
    check_output({16'h0, pc});
    rd_addr2 = 4'd15;
    apply_stimulus(1'b1, 4'h0, 4'd15, 32'h0000_FFFF, 1'b0, 4'd0, 1'b1);
    expect_val("pc_bypass_rd2", 32'h0000_FFFF);
    #1 check_output(rd_data2);
    @(negedge clk);
    expect_val("pc_write_wins", 32'hFFFF);
    check_output({16'h0, pc});
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    expect_val("pc_wrap", 32'h0);
    check_output({16'h0, pc});

    // Scoreboard: issue R5, stall until writeback
    rd_addr2 = 4'd5;
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0);
    expect_val("stall_before_issue_edge", 32'h0);
    #1 check_output({31'h0, stall});
    @(negedge clk);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    expect_val("pending_r5", 32'h0020); check_output({16'h0, pending});
    expect_val("stall_r5", 32'h1);      check_output({31'h0, stall});
    @(negedge clk);
    expect_val("stall_r5_hold", 32'h1); check_output({31'h0, stall});
    apply_stimulus(1'b1, 4'h0, 4'd5, 32'h0000_0055, 1'b0, 4'd0, 1'b0);
    #1;
    expect_val("stall_same_cycle_wb", 32'h1); check_output({31'h0, stall});
    expect_val("bypass_r5", 32'h55);          check_output(rd_data2);
    @(negedge clk);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    expect_val("stall_cleared", 32'h0);   check_output({31'h0, stall});
    expect_val("pending_cleared", 32'h0); check_output({16'h0, pending});
    expect_val("r5_stored", 32'h55);      #1 check_output(rd_data2);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b1, 4'h0, 4'd5, 32'h0000_0066, 1'b1, 4'd5, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    expect_val("set_wins_over_clear", 32'h0020); check_output({16'h0, pending});
    apply_stimulus(1'b1, 4'h0, 4'd5, 32'h0000_0077, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    expect_val("pending_r5_final", 32'h0); check_output({16'h0, pending});

    // Gated CMP write must not clear pending
    rd_addr1 = 4'd7;
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b1, 4'hB, 4'd7, 32'h0000_0BAD, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    expect_val("cmp_keeps_pending", 32'h0080); check_output({16'h0, pending});
    expect_val("cmp_no_write_r7", 32'h0);      #1 check_output(rd_data1);
    apply_stimulus(1'b1, 4'h0, 4'd7, 32'h0000_0777, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    expect_val("alu_clears_pending", 32'h0); check_output({16'h0, pending});
    expect_val("r7_written", 32'h777);       #1 check_output(rd_data1);

    // Asynchronous reset mid-stream
    apply_stimulus(1'b1, 4'h0, 4'd2, 32'h0000_0005, 1'b1, 4'd5, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b1, 4'h0, 4'd9, 32'h0000_0099, 1'b1, 4'd9, 1'b1);
    rd_addr1 = 4'd2;
    expect_val("pre_reset_pending", 32'h00A0); #1 check_output({16'h0, pending});
    expect_val("pre_reset_r2", 32'h5);         check_output(rd_data1);
    #1 reset = 1'b0;
    #1;
    expect_val("async_reset_pending", 32'h0); check_output({16'h0, pending});
    expect_val("async_reset_r2", 32'h0);      check_output(rd_data1);
    expect_val("async_reset_pc", 32'h1);      check_output({16'h0, pc});
    expect_val("async_reset_stall", 32'h0);   check_output({31'h0, stall});
    @(negedge clk);
    apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    rd_addr1 = 4'd9;
    #1;
    expect_val("inflight_write_dropped", 32'h0); check_output(rd_data1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
